// File: rtl/cti_queue_param.sv
// Control-transfer-instruction queue for in-order branch predictor update.
// Fetch allocates one entry per CTI in program order, execute records the
// resolved target/direction, retire marks entries committed, and committed
// entries drain one per cycle to the BTB/BPB update port. A retire-level
// recover truncates the queue at the commit pointer; a mispredict squash
// truncates it just past the mispredicted branch.
module cti_queue_param #(
    parameter  int FETCH_WIDTH  = 4,
    parameter  int RETIRE_WIDTH = 4,
    parameter  int DEPTH        = 32,
    parameter  int PC_W         = 32,
    parameter  int TYPE_W       = 2,
    localparam int LOG          = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,

    // Allocation from fetch
    input  logic                        alloc_en_i,
    input  logic [FETCH_WIDTH-1:0]      ctrl_vector_i,
    input  logic [FETCH_WIDTH*PC_W-1:0] pc_i,
    input  logic [FETCH_WIDTH*TYPE_W-1:0] type_i,
    output logic [FETCH_WIDTH*LOG-1:0]  tag_o,
    output logic                        full_o,

    // Resolution from execute
    input  logic                        resolve_en_i,
    input  logic [LOG-1:0]              resolve_tag_i,
    input  logic [PC_W-1:0]             resolve_target_i,
    input  logic                        resolve_taken_i,
    input  logic                        resolve_mispred_i,

    // Retire
    input  logic [RETIRE_WIDTH-1:0]     commit_cti_i,
    input  logic                        recover_i,

    // Predictor update port
    output logic                        upd_valid_o,
    input  logic                        upd_ready_i,
    output logic [PC_W-1:0]             upd_pc_o,
    output logic [PC_W-1:0]             upd_target_o,
    output logic                        upd_dir_o,
    output logic [TYPE_W-1:0]           upd_type_o,

    // Occupancy
    output logic [LOG:0]                count_o,
    output logic                        empty_o
);

    // Pointers carry one extra wrap bit so that full and empty are distinct.
    typedef logic [LOG:0]   ptr_t;
    typedef logic [LOG-1:0] idx_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);

    ptr_t headPtr;
    ptr_t commitPtr;
    ptr_t tailPtr;

    // Per-entry status bits (reset) and payload storage (not reset)
    logic [DEPTH-1:0]  resolvedQ;
    logic [DEPTH-1:0]  committedQ;
    logic [PC_W-1:0]   pcMem     [DEPTH];
    logic [TYPE_W-1:0] typeMem   [DEPTH];
    logic [PC_W-1:0]   targetMem [DEPTH];
    logic              dirMem    [DEPTH];

    // Combinational control
    ptr_t occupancy;
    ptr_t freeSlots;
    ptr_t allocCount;
    ptr_t commitCount;
    idx_t laneOffset [FETCH_WIDTH];
    idx_t laneIdx    [FETCH_WIDTH];
    idx_t headIdx;
    idx_t squashDist;
    ptr_t squashTail;
    ptr_t commitNext;
    logic squashGo;
    logic resolveGo;
    logic allocGo;
    logic updPop;

    // Running popcount over the fetch lanes gives each lane its slot offset.
    always_comb begin
        // NOTE: a running sum inside always_comb must use blocking '=' so each
        // iteration sees the previous lane's total; registers use '<=' only.
        allocCount = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            laneOffset[k] = allocCount[LOG-1:0];
            laneIdx[k]    = tailPtr[LOG-1:0] + allocCount[LOG-1:0];
            if (ctrl_vector_i[k]) begin
                allocCount = allocCount + PTR_ONE;
            end
        end
    end

    // Lane tags: slot index for CTI lanes, zero for empty lanes.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise lanes that are skipped would infer latches.
        tag_o = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (ctrl_vector_i[k]) begin
                tag_o[k*LOG +: LOG] = laneIdx[k];
            end
        end
    end

    // Number of CTIs retiring this cycle.
    always_comb begin
        commitCount = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (commit_cti_i[i]) begin
                commitCount = commitCount + PTR_ONE;
            end
        end
    end

    // Occupancy, admission and recovery arithmetic.
    always_comb begin
        occupancy  = tailPtr - headPtr;
        freeSlots  = PTR_DEPTH - occupancy;
        full_o     = alloc_en_i & (allocCount > freeSlots);
        empty_o    = (occupancy == '0);
        count_o    = occupancy;
        headIdx    = headPtr[LOG-1:0];

        // The update port goes quiet during a recover so the head never moves.
        upd_valid_o = committedQ[headIdx] & ~empty_o & ~recover_i;
        updPop      = upd_valid_o & upd_ready_i;

        squashGo  = resolve_en_i & resolve_mispred_i & ~recover_i;
        resolveGo = resolve_en_i & ~recover_i;
        allocGo   = alloc_en_i & ~full_o & ~recover_i & ~squashGo;

        // The squashed tail sits one past the branch; its distance from the
        // commit pointer restores the wrap bit that the short tag lacks.
        commitNext = commitPtr + commitCount;
        squashDist = resolve_tag_i - commitPtr[LOG-1:0];
        squashTail = commitPtr + {1'b0, squashDist} + PTR_ONE;
    end

    // Head entry is presented on the update port directly from storage.
    always_comb begin
        upd_pc_o     = pcMem[headIdx];
        upd_target_o = targetMem[headIdx];
        upd_type_o   = typeMem[headIdx];
        // A CTI that retires without ever resolving reports not-taken.
        upd_dir_o    = dirMem[headIdx] & resolvedQ[headIdx];
    end

    // Pointer update: recover beats squash beats allocate; commit and pop are
    // independent of all three.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            headPtr   <= '0;
            commitPtr <= '0;
            tailPtr   <= '0;
        end else begin
            commitPtr <= commitNext;
            if (updPop) begin
                headPtr <= headPtr + PTR_ONE;
            end
            if (recover_i) begin
                tailPtr <= commitNext;
            end else if (squashGo) begin
                tailPtr <= squashTail;
            end else if (allocGo) begin
                tailPtr <= tailPtr + allocCount;
            end
        end
    end

    // Status bits: cleared on allocation, resolved by execute, committed by
    // retire, and the committed bit released when the head drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resolvedQ  <= '0;
            committedQ <= '0;
        end else begin
            if (allocGo) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    if (ctrl_vector_i[k]) begin
                        resolvedQ[laneIdx[k]]  <= 1'b0;
                        committedQ[laneIdx[k]] <= 1'b0;
                    end
                end
            end
            if (resolveGo) begin
                resolvedQ[resolve_tag_i] <= 1'b1;
            end
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                if (ptr_t'(i) < commitCount) begin
                    committedQ[commitPtr[LOG-1:0] + idx_t'(i)] <= 1'b1;
                end
            end
            if (updPop) begin
                committedQ[headIdx] <= 1'b0;
            end
        end
    end

    // Payload storage written by fetch (pc/type) and execute (target/dir).
    // NOTE: payload arrays are deliberately not reset; the status bits above
    // guarantee that a stale payload is never presented as valid.
    always_ff @(posedge clk) begin
        if (allocGo) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (ctrl_vector_i[k]) begin
                    pcMem[laneIdx[k]]   <= pc_i[k*PC_W +: PC_W];
                    typeMem[laneIdx[k]] <= type_i[k*TYPE_W +: TYPE_W];
                end
            end
        end
        if (resolveGo) begin
            targetMem[resolve_tag_i] <= resolve_target_i;
            dirMem[resolve_tag_i]    <= resolve_taken_i;
        end
    end

endmodule
